// File: rtl/mux_arb_n.sv
// N:1 selector with a registered output stage, fixed-select or round-robin arbitration.
// Optional packet lock (in_last/out_last) is enabled by defining MUX_ARB_N_LOCK_EN.
module mux_arb_n #(
    parameter int WIDTH = 64,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data [N],
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
`ifdef MUX_ARB_N_LOCK_EN
    input  logic [N-1:0]     in_last,
    output logic             out_last,
`endif
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake: a word moves on a port in any cycle where valid and ready are both high.
    // Ready on an input is granted only when the output register can load this cycle.
    logic             load_en;
    logic             grant_hit;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] nxt_ptr;
    logic [31:0]      ptr_u;
    logic [31:0]      sel_u;
    logic             ptr_upd;
`ifdef MUX_ARB_N_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
`endif

    always_comb begin
        load_en   = !out_valid || out_ready;
        ptr_u     = 32'(ptr);
        sel_u     = 32'(sel);
        grant_hit = 1'b0;
        grant_idx = '0;
`ifdef MUX_ARB_N_LOCK_EN
        if (locked) begin
            grant_hit = in_valid[lock_ch];
            grant_idx = lock_ch;
        end else begin
`else
        begin
`endif
            if (!mode) begin
                // An out-of-range sel matches no channel, so nothing is granted.
                for (int i = 0; i < N; i++) begin
                    if (32'(i) == sel_u && in_valid[i]) begin
                        grant_hit = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end else begin
                // Lowest valid channel overall covers the wrap; lowest at/above ptr wins if any.
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_hit = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i] && 32'(i) >= ptr_u) begin
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        end

        nxt_ptr = (32'(grant_idx) == 32'(N - 1)) ? '0 : grant_idx + 1'b1;
`ifdef MUX_ARB_N_LOCK_EN
        ptr_upd = mode && (!locked || in_last[grant_idx]);
`else
        ptr_upd = mode;
`endif

        in_ready = '0;
        if (grant_hit && load_en && reset_n) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
`ifdef MUX_ARB_N_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (load_en) begin
            out_valid <= grant_hit;
            if (grant_hit) begin
                out_data <= in_data[grant_idx];
                out_src  <= grant_idx;
                if (ptr_upd) begin
                    ptr <= nxt_ptr;
                end
`ifdef MUX_ARB_N_LOCK_EN
                out_last <= in_last[grant_idx];
                locked   <= !in_last[grant_idx];
                lock_ch  <= grant_idx;
`endif
            end
        end
    end

endmodule
